unified_mem_arbiter: RTL and testbench

Shares one single-port SRAM with a 1-cycle synchronous read (the `SP_SRAM` type used for I-memory and D-memory) between the core's instruction-fetch port and its load/store port. This lets a unified-memory build of `RISCV_TOP` run against a single `SP_SRAM`. The block grants one access per cycle, drives the SRAM's active-low control pins, routes the read data back to the requester that issued the read, and holds each requester's last read data stable. The core stalls its fetch or memory stage while its grant is low.

---
 rtl/riscv_mem_pkg.sv | 19 +
 rtl/uma_rdata_hold.sv | 38 +++
 rtl/unified_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared memory-side definitions for the RISC-V core memory blocks:
// return-owner encoding, idle pin levels for the SP_SRAM, bus widths.
package riscv_mem_pkg;

    localparam int BE_W   = 4;
    localparam int DATA_W = 32;

    // Which requester the read in flight belongs to.
    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_D    = 2'd1,
        RET_I    = 2'd2
    } ret_owner_e;

    // SRAM control pins are active-low; these are their inactive levels.
    localparam logic MEM_CSN_IDLE = 1'b1;
    localparam logic MEM_WEN_READ = 1'b1;

endpackage

// File: rtl/uma_rdata_hold.sv
// Per-requester read return: RVALID generation, pass-through of the SRAM
// output in the return cycle, and a hold register that keeps the last read
// word stable on RDATA until this requester's next read completes.
module uma_rdata_hold
    import riscv_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              is_owner,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] hold_d;
    logic [DATA_W-1:0] hold_q;

    // Capture the returning word only when this requester owns the return.
    always_comb begin
        hold_d = hold_q;
        if (is_owner) begin
            hold_d = mem_dout;
        end
    end

    // Hold register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign rvalid = is_owner;
    assign rdata  = is_owner ? mem_dout : hold_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port SRAM (1-cycle synchronous read) between the
// core's fetch port (I) and load/store port (D). One access per cycle,
// D has priority; read data is routed back to the issuing port.
// Optional feature macro: UMA_STARVE_GUARD_EN (starve counter + I override).
module unified_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int AWIDTH       = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              D_REQ,
    input  logic              D_WEN,
    input  logic [BE_W-1:0]   D_BE,
    input  logic [31:0]       D_ADDR,
    input  logic [31:0]       D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [31:0]       D_RDATA,
    input  logic              I_REQ,
    input  logic [31:0]       I_ADDR,
    output logic              I_GNT,
    output logic              I_RVALID,
    output logic [31:0]       I_RDATA,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [BE_W-1:0]   MEM_BE,
    output logic [AWIDTH-1:0] MEM_ADDR,
    output logic [31:0]       MEM_DI,
    input  logic [31:0]       MEM_DOUT
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    logic       d_win;
    logic       i_win;
    logic       i_force;
    ret_owner_e owner_d;
    ret_owner_e owner_q;

    // Byte offset and bits above the SRAM range are not part of the word address.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{D_ADDR[31:AWIDTH+2], D_ADDR[1:0],
                                I_ADDR[31:AWIDTH+2], I_ADDR[1:0]};

`ifdef UMA_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_d;
    logic [3:0] starve_q;

    assign i_force = I_REQ && (starve_q == STARVE_MAX);

    // Count D wins while I is waiting; any I grant or idle I clears it.
    always_comb begin
        starve_d = starve_q;
        if (!I_REQ || i_win) begin
            starve_d = '0;
        end else if (d_win && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Starve counter register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign i_force = 1'b0;
`endif

    // Same-cycle arbitration; nothing is granted while reset is held.
    always_comb begin
        d_win = 1'b0;
        i_win = 1'b0;
        if (RSTn) begin
            if (i_force) begin
                i_win = 1'b1;
            end else if (D_REQ) begin
                d_win = 1'b1;
            end else if (I_REQ) begin
                i_win = 1'b1;
            end
        end
    end

    assign D_GNT = d_win;
    assign I_GNT = i_win;

    // Drive the SRAM pins from the winner, or park them idle.
    always_comb begin
        MEM_CSN  = MEM_CSN_IDLE;
        MEM_WEN  = MEM_WEN_READ;
        MEM_BE   = '0;
        MEM_ADDR = '0;
        MEM_DI   = '0;
        if (d_win) begin
            MEM_CSN  = 1'b0;
            MEM_WEN  = D_WEN;
            MEM_BE   = D_BE;
            MEM_ADDR = D_ADDR[AWIDTH+1:2];
            MEM_DI   = D_WDATA;
        end else if (i_win) begin
            MEM_CSN  = 1'b0;
            MEM_ADDR = I_ADDR[AWIDTH+1:2];
        end
    end

    // Return-owner next state: only reads produce a return next cycle.
    always_comb begin
        owner_d = RET_NONE;
        if (d_win && D_WEN) begin
            owner_d = RET_D;
        end else if (i_win) begin
            owner_d = RET_I;
        end
    end

    // Return-owner register; reset drops any return in flight.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            owner_q <= RET_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    uma_rdata_hold u_d_hold (
        .clk      (CLK),
        .rst_n    (RSTn),
        .is_owner (owner_q == RET_D),
        .mem_dout (MEM_DOUT),
        .rvalid   (D_RVALID),
        .rdata    (D_RDATA)
    );

    uma_rdata_hold u_i_hold (
        .clk      (CLK),
        .rst_n    (RSTn),
        .is_owner (owner_q == RET_I),
        .mem_dout (MEM_DOUT),
        .rvalid   (I_RVALID),
        .rdata    (I_RDATA)
    );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: SRAM model, directed scenarios, then
// random traffic checked every cycle against a behavioural model.
module tb_unified_mem_arbiter;

    localparam int AW  = 12;
    localparam int LIM = 4;
    localparam int NW  = 1 << AW;

    logic          CLK;
    logic          RSTn;
    logic          D_REQ, D_WEN;
    logic [3:0]    D_BE;
    logic [31:0]   D_ADDR, D_WDATA;
    logic          D_GNT, D_RVALID;
    logic [31:0]   D_RDATA;
    logic          I_REQ;
    logic [31:0]   I_ADDR;
    logic          I_GNT, I_RVALID;
    logic [31:0]   I_RDATA;
    logic          MEM_CSN, MEM_WEN;
    logic [3:0]    MEM_BE;
    logic [AW-1:0] MEM_ADDR;
    logic [31:0]   MEM_DI;
    logic [31:0]   MEM_DOUT;

    int checks = 0;
    int errors = 0;

    unified_mem_arbiter #(.AWIDTH(AW), .STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .D_REQ(D_REQ), .D_WEN(D_WEN), .D_BE(D_BE), .D_ADDR(D_ADDR),
        .D_WDATA(D_WDATA), .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID),
        .I_RDATA(I_RDATA),
        .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE),
        .MEM_ADDR(MEM_ADDR), .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- SRAM model (environment) ----------------
    logic [31:0] sram [NW];
    always @(posedge CLK) begin
        if (!MEM_CSN) begin
            if (!MEM_WEN) begin
                for (int b = 0; b < 4; b++)
                    if (MEM_BE[b]) sram[MEM_ADDR][8*b +: 8] = MEM_DI[8*b +: 8];
            end else begin
                MEM_DOUT <= sram[MEM_ADDR];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] ref_mem [NW];
    int          m_ret;        // 0 none, 1 D read pending, 2 I read pending
    logic [31:0] m_ret_data;
    logic [31:0] m_d_hold, m_i_hold;
    int          m_streak;

    function automatic int word_of(input logic [31:0] byte_addr);
        return int'((byte_addr / 4) % NW);
    endfunction

    // Compare process: every cycle at the falling edge, derive what the
    // outputs must be from the model, compare, then commit the cycle.
    always @(negedge CLK) begin
        int          win;          // 0 none, 1 D, 2 I
        logic        e_drv, e_irv, e_csn, e_wen;
        logic [31:0] e_drd, e_ird, e_di;
        logic [3:0]  e_be;
        int          e_addr;

        win = 0; e_drv = 0; e_irv = 0; e_csn = 1; e_wen = 1;
        e_be = 0; e_addr = 0; e_di = 0;
        e_drd = m_d_hold; e_ird = m_i_hold;

        if (!RSTn) begin
            e_drd = 0; e_ird = 0;
        end else begin
            e_drv = (m_ret == 1);
            e_irv = (m_ret == 2);
            if (e_drv) e_drd = m_ret_data;
            if (e_irv) e_ird = m_ret_data;
`ifdef UMA_STARVE_GUARD_EN
            if (I_REQ && m_streak >= LIM) win = 2;
            else
`endif
            if (D_REQ) win = 1;
            else if (I_REQ) win = 2;
            if (win == 1) begin
                e_csn = 0; e_wen = D_WEN; e_be = D_BE;
                e_addr = word_of(D_ADDR); e_di = D_WDATA;
            end else if (win == 2) begin
                e_csn = 0; e_addr = word_of(I_ADDR);
            end
        end

        chk("d_gnt", D_GNT, win == 1);
        chk("i_gnt", I_GNT, win == 2);
        chk("mem_csn", MEM_CSN, e_csn);
        chk("mem_wen", MEM_WEN, e_wen);
        chk("mem_be", MEM_BE, e_be);
        chk("mem_addr", MEM_ADDR, e_addr);
        chk("mem_di", MEM_DI, e_di);
        chk("d_rvalid", D_RVALID, e_drv);
        chk("d_rdata", D_RDATA, e_drd);
        chk("i_rvalid", I_RVALID, e_irv);
        chk("i_rdata", I_RDATA, e_ird);

        if (!RSTn) begin
            m_ret = 0; m_d_hold = 0; m_i_hold = 0; m_streak = 0;
        end else begin
            m_d_hold = e_drd;
            m_i_hold = e_ird;
            m_ret = 0;
            if (win == 1 && D_WEN) begin
                m_ret = 1; m_ret_data = ref_mem[e_addr];
            end else if (win == 1) begin
                for (int b = 0; b < 4; b++)
                    if (D_BE[b]) ref_mem[e_addr][8*b +: 8] = D_WDATA[8*b +: 8];
            end else if (win == 2) begin
                m_ret = 2; m_ret_data = ref_mem[e_addr];
            end
            if (!I_REQ || win == 2) m_streak = 0;
            else if (win == 1 && m_streak < LIM) m_streak = m_streak + 1;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        D_REQ = 0; I_REQ = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        string pat, exp_pat;
        logic  d_gs, i_gs;

        for (int i = 0; i < NW; i++) begin
            sram[i]    = (i * 32'h0100_0193) ^ 32'h5A5A_0000;
            ref_mem[i] = (i * 32'h0100_0193) ^ 32'h5A5A_0000;
        end
        sram[4] = 32'h0050_0093; ref_mem[4] = 32'h0050_0093;
        MEM_DOUT = 0;
        m_ret = 0; m_ret_data = 0; m_d_hold = 0; m_i_hold = 0; m_streak = 0;

        // Reset with both requests raised: grants must stay forced low.
        RSTn = 0; D_REQ = 1; D_WEN = 1; D_BE = 4'hF; D_ADDR = 0; D_WDATA = 0;
        I_REQ = 1; I_ADDR = 0;
        @(negedge CLK);
        chk("rst_d_gnt", D_GNT, 0);
        chk("rst_i_gnt", I_GNT, 0);
        chk("rst_mem_csn", MEM_CSN, 1);
        chk("rst_mem_wen", MEM_WEN, 1);
        repeat (2) step();
        idle();
        RSTn = 1;
        step();

        // I-only fetch of word 4.
        I_REQ = 1; I_ADDR = 32'h10;
        @(negedge CLK);
        chk("fetch_gnt", I_GNT, 1);
        chk("fetch_addr", MEM_ADDR, 4);
        step(); idle();
        @(negedge CLK);
        chk("fetch_rvalid", I_RVALID, 1);
        chk("fetch_rdata", I_RDATA, 32'h0050_0093);
        step();
        @(negedge CLK);
        chk("fetch_hold", I_RDATA, 32'h0050_0093);
        chk("fetch_rvalid_drop", I_RVALID, 0);

        // D store then load at 0x3C00.
        step();
        D_REQ = 1; D_WEN = 0; D_BE = 4'hF; D_ADDR = 32'h3C00; D_WDATA = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("store_addr", MEM_ADDR, 12'hF00);
        chk("store_wen", MEM_WEN, 0);
        step();
        D_WEN = 1;
        @(negedge CLK);
        chk("store_no_rvalid", D_RVALID, 0);
        chk("load_gnt", D_GNT, 1);
        step(); idle();
        @(negedge CLK);
        chk("load_rvalid", D_RVALID, 1);
        chk("load_rdata", D_RDATA, 32'hDEAD_BEEF);
        chk("i_hold_across_d", I_RDATA, 32'h0050_0093);
        step();

        // Both requests high for 10 cycles.
        D_REQ = 1; D_WEN = 1; D_ADDR = 32'h8; I_REQ = 1; I_ADDR = 32'hC;
        pat = "";
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (D_GNT) pat = {pat, "D"};
            else if (I_GNT) pat = {pat, "I"};
            else pat = {pat, "-"};
            step();
        end
`ifdef UMA_STARVE_GUARD_EN
        exp_pat = "DDDDIDDDDI";
`else
        exp_pat = "DDDDDDDDDD";
`endif
        checks++;
        if (pat != exp_pat) begin
            errors++;
            $display("FAIL grant_pattern: got %s expected %s", pat, exp_pat);
        end
        idle();
        step();

        // Alternating D load / I fetch every cycle.
        for (int k = 0; k < 8; k++) begin
            idle();
            if (k % 2 == 0) begin D_REQ = 1; D_WEN = 1; D_ADDR = 32'(k * 4 + 32'h40); end
            else begin I_REQ = 1; I_ADDR = 32'(k * 4 + 32'h80); end
            step();
        end
        idle();
        step();

        // Reset in the cycle after an I grant drops the return.
        I_REQ = 1; I_ADDR = 32'h10;
        @(negedge CLK);
        chk("rst_case_gnt", I_GNT, 1);
        step();
        idle(); RSTn = 0;
        @(negedge CLK);
        chk("rst_case_rvalid", I_RVALID, 0);
        step();
        RSTn = 1;
        @(negedge CLK);
        chk("rel_csn", MEM_CSN, 1);
        chk("rel_i_rdata", I_RDATA, 0);
        chk("rel_i_rvalid", I_RVALID, 0);
        step();

        // Random traffic with handshake-respecting requesters.
        d_gs = 0; i_gs = 0;
        for (int n = 0; n < 3000; n++) begin
            RSTn = ($urandom_range(0, 199) != 0);
            if (D_REQ && !d_gs) begin
                if ($urandom_range(0, 19) == 0) D_REQ = 0;
            end else begin
                D_REQ = ($urandom_range(0, 99) < 60);
                D_WEN = $urandom_range(0, 1);
                D_BE = 4'($urandom_range(0, 15));
                D_ADDR = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)
                             | ($urandom_range(0, 1) << 20));
                D_WDATA = $urandom;
            end
            if (I_REQ && !i_gs) begin
                if ($urandom_range(0, 19) == 0) I_REQ = 0;
            end else begin
                I_REQ = ($urandom_range(0, 99) < 50);
                I_ADDR = 32'(($urandom_range(0, 15) << 2) | ($urandom_range(0, 1) << 24));
            end
            @(negedge CLK);
            d_gs = D_GNT; i_gs = I_GNT;
            step();
        end
        idle(); RSTn = 1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
